// File: rtl/mod_timer_pkg.sv
// Shared types and timing constants for mod_timer.
// MOD_TIMER_RADIX4_EN selects 2 quotient bits per cycle; otherwise 1.
package mod_timer_pkg;

`ifdef MOD_TIMER_RADIX4_EN
  localparam int unsigned RADIX_BITS = 2;
`else
  localparam int unsigned RADIX_BITS = 1;
`endif

  localparam int unsigned DIV_STEPS = 64 / RADIX_BITS;
  localparam int unsigned PERIOD    = 2 * DIV_STEPS + 2;
  localparam int unsigned CNT_W     = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    DIV_T,
    DIV_C,
    PUBLISH
  } state_e;

endpackage

// File: rtl/mod_timer_udiv64.sv
// Sequential restoring divider: 64-bit dividend, 32-bit divisor, RADIX_BITS per cycle.
// The start cycle already retires the first step, so a division takes DIV_STEPS edges.
module udiv64
  import mod_timer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [63:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [63:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [63:0]      quo_q, quo_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      div_q, div_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  // One radix-2 step: shift the next dividend bit into the partial remainder.
  function automatic logic [95:0] div_step(input logic [31:0] rem,
                                           input logic [63:0] quo,
                                           input logic [31:0] dvs);
    logic [32:0] trial;
    logic        qbit;
    trial = {rem, quo[63]};
    qbit  = 1'b0;
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      qbit  = 1'b1;
    end
    return {trial[31:0], quo[62:0], qbit};
  endfunction

  always_comb begin
    div_d = start_i ? divisor_i : div_q;
    rem_d = start_i ? 32'd0 : rem_q;
    quo_d = start_i ? dividend_i : quo_q;
    for (int k = 0; k < int'(RADIX_BITS); k++) begin
      {rem_d, quo_d} = div_step(rem_d, quo_d, div_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      quo_q  <= 64'd0;
      rem_q  <= 32'd0;
      div_q  <= 32'd0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        div_q  <= div_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        cnt_q  <= CNT_W'(DIV_STEPS - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mod_timer.sv
// Modulation sample index: IDX = (SYS_TIME / FREQ_DIV_M) mod (CYCLE_M + 1), refreshed every PERIOD.
// Build option MOD_TIMER_RADIX4_EN halves both division phases.
module mod_timer
  import mod_timer_pkg::*;
#(
  parameter int unsigned MIN_FREQ_DIV = 512
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] SYS_TIME,
  input  logic [15:0] CYCLE_M,
  input  logic [31:0] FREQ_DIV_M,
  output logic [15:0] IDX,
  output logic        IDX_VALID,
  output logic        ERR
);

  state_e      state_q;
  logic [15:0] cyc_q;
  logic        snap_err_q;
  logic [15:0] idx_q;
  logic        valid_q;
  logic        err_q;

  logic        err_c;
  logic        start_c;
  logic [63:0] dvd_c;
  logic [31:0] dvs_c;
  logic        div_done;
  logic [63:0] div_quo;
  logic [31:0] div_rem;

  assign err_c = (FREQ_DIV_M < MIN_FREQ_DIV);

  // IDLE feeds the live inputs (the T/D snapshot lives in the divider's operand regs);
  // an illegal divisor is swapped for 1 so the datapath never divides by zero.
  always_comb begin
    start_c = 1'b0;
    dvd_c   = div_quo;
    dvs_c   = 32'(cyc_q) + 32'd1;
    case (state_q)
      IDLE: begin
        start_c = 1'b1;
        dvd_c   = SYS_TIME;
        dvs_c   = err_c ? 32'd1 : FREQ_DIV_M;
      end
      DIV_T:   start_c = div_done;
      default: ;
    endcase
  end

  udiv64 u_div (
    .clk_i      (CLK),
    .rst_n_i    (RST_N),
    .start_i    (start_c),
    .dividend_i (dvd_c),
    .divisor_i  (dvs_c),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cyc_q      <= 16'd0;
      snap_err_q <= 1'b0;
      idx_q      <= 16'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cyc_q      <= CYCLE_M;
          snap_err_q <= err_c;
          state_q    <= DIV_T;
        end
        DIV_T:   if (div_done) state_q <= DIV_C;
        DIV_C:   if (div_done) state_q <= PUBLISH;
        PUBLISH: begin
          idx_q   <= snap_err_q ? 16'd0 : 16'(div_rem);
          err_q   <= snap_err_q;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IDX       = idx_q;
  assign IDX_VALID = valid_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_mod_timer.sv
// Directed + randomized bench for mod_timer against an arithmetic (T/D)%(C+1) model.
module tb_mod_timer;

`ifdef MOD_TIMER_RADIX4_EN
  localparam int PER   = 66;
  localparam int STEPS = 32;
`else
  localparam int PER   = 130;
  localparam int STEPS = 64;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [63:0] SYS_TIME;
  logic [15:0] CYCLE_M;
  logic [31:0] FREQ_DIV_M;
  logic [15:0] IDX;
  logic        IDX_VALID;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mod_timer dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SYS_TIME  (SYS_TIME),
    .CYCLE_M   (CYCLE_M),
    .FREQ_DIV_M(FREQ_DIV_M),
    .IDX       (IDX),
    .IDX_VALID (IDX_VALID),
    .ERR       (ERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_idx(input logic [63:0] t, input logic [31:0] d,
                                            input logic [15:0] c);
    longint unsigned q;
    longint unsigned n;
    if (d < 32'd512) return 16'd0;
    q = t / 64'(d);
    n = 64'(c) + 64'd1;
    return 16'(q % n);
  endfunction

  // Returns edges elapsed until the strobe is seen (bounded).
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (IDX_VALID !== 1'b1 && n < 3 * PER);
    chk("strobe_seen", 64'(IDX_VALID), 64'd1);
  endtask

  // Called in the IDLE cycle; the next edge snapshots t/d/c.
  task automatic run_txn(input logic [63:0] t, input logic [31:0] d, input logic [15:0] c,
                         input bit scramble, input string tag);
    int n;
    SYS_TIME   = t;
    FREQ_DIV_M = d;
    CYCLE_M    = c;
    @(posedge CLK); #1;
    if (scramble) begin
      SYS_TIME   = {$urandom, $urandom};
      FREQ_DIV_M = $urandom_range(0, 1000);
      CYCLE_M    = 16'($urandom);
    end
    wait_strobe(n);
    chk({tag, "_period"}, 64'(n), 64'(PER - 1));
    chk({tag, "_idx"}, 64'(IDX), 64'(model_idx(t, d, c)));
    chk({tag, "_err"}, 64'(ERR), 64'(d < 32'd512));
  endtask

  // Reset for one cycle in DIV_T cycle 30, then expect a full period to the first strobe.
  task automatic reset_mid(input string tag);
    int n;
    SYS_TIME   = 64'd5000;
    FREQ_DIV_M = 32'd1000;
    CYCLE_M    = 16'd3;
    @(posedge CLK); #1;
    repeat (30) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    chk({tag, "_rst_idx"}, 64'(IDX), 64'd0);
    chk({tag, "_rst_valid"}, 64'(IDX_VALID), 64'd0);
    chk({tag, "_rst_err"}, 64'(ERR), 64'd0);
    SYS_TIME   = 64'd12345678;
    FREQ_DIV_M = 32'd600;
    CYCLE_M    = 16'd99;
    RST_N      = 1'b1;
    wait_strobe(n);
    chk({tag, "_first_period"}, 64'(n), 64'(PER));
    chk({tag, "_idx"}, 64'(IDX), 64'(model_idx(64'd12345678, 32'd600, 16'd99)));
  endtask

  initial begin
    int n;
    logic [63:0] t;
    logic [31:0] d;
    logic [15:0] c;

    RST_N      = 1'b0;
    SYS_TIME   = 64'd0;
    CYCLE_M    = 16'd0;
    FREQ_DIV_M = 32'd0;
    repeat (4) @(posedge CLK);
    #1;
    chk("reset_idx", 64'(IDX), 64'd0);
    chk("reset_valid", 64'(IDX_VALID), 64'd0);
    chk("reset_err", 64'(ERR), 64'd0);
    RST_N = 1'b1;

    // Basic case, strobe is one cycle wide, IDX holds, period repeats.
    run_txn(64'd10240, 32'd512, 16'd7, 1'b0, "t1");
    chk("t1_idx_const", 64'(IDX), 64'd4);
    @(posedge CLK); #1;
    chk("t1_pulse_low", 64'(IDX_VALID), 64'd0);
    chk("t1_hold", 64'(IDX), 64'd4);
    wait_strobe(n);
    chk("t1_period", 64'(n), 64'(PER - 1));
    chk("t1_again", 64'(IDX), 64'd4);

    reset_mid("t5a");

    // Extreme operands.
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, "t2");
    chk("t2_idx_const", 64'(IDX), 64'd1);

    // Error divisors, boundary, then recovery.
    run_txn(64'd987654321, 32'd100, 16'd5, 1'b1, "t3_d100");
    chk("t3_err_const", 64'(ERR), 64'd1);
    run_txn(64'd1536, 32'd512, 16'd9, 1'b0, "t3_recover");
    chk("t3_recover_const", 64'(IDX), 64'd3);
    run_txn(64'd777777, 32'd0, 16'd4, 1'b1, "t3_d0");
    run_txn(64'd777777, 32'd511, 16'd4, 1'b1, "t3_d511");
    reset_mid("t5b");
    run_txn(64'd777777, 32'd512, 16'd4, 1'b1, "t3_d512");

    // CYCLE_M = 0 always yields index 0.
    for (int i = 0; i < 100; i++) begin
      run_txn({$urandom, $urandom}, $urandom_range(512, 32'hFFFF_FFFF), 16'd0, 1'b1, "t4_c0");
    end

    // Inputs change mid-DIV_C: current strobe uses the old snapshot.
    SYS_TIME   = 64'd1003000;
    FREQ_DIV_M = 32'd1000;
    CYCLE_M    = 16'd7;
    @(posedge CLK); #1;
    repeat (STEPS + 10) @(posedge CLK);
    #1;
    FREQ_DIV_M = 32'd513;
    CYCLE_M    = 16'd10;
    wait_strobe(n);
    chk("t6_old_idx", 64'(IDX), 64'(model_idx(64'd1003000, 32'd1000, 16'd7)));
    wait_strobe(n);
    chk("t6_new_period", 64'(n), 64'(PER));
    chk("t6_new_idx", 64'(IDX), 64'(model_idx(64'd1003000, 32'd513, 16'd10)));

    // Randomized operands with mid-transaction input scrambling.
    for (int i = 0; i < 300; i++) begin
      t = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(0, 600);
        1:       d = $urandom_range(512, 5000);
        default: d = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       c = 16'hFFFF;
        1:       c = 16'($urandom_range(0, 3));
        default: c = 16'($urandom);
      endcase
      run_txn(t, d, c, 1'b1, "t6_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
